button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
// - Input-side companion to the LED blink/counter outputs: turns one raw,
//   asynchronous, bouncing push-button pin into clean, clock-synchronous events.
// - Outputs: debounced level, 1-cycle press/release pulses, a 1-cycle long-press
//   pulse and an 8-bit press counter.
// - Sits between a board button pin and user logic, e.g. LED mode select or
//   counter reset.
// PARAMETERS
// - p_active_low  0         1 = pin reads 0 when pressed; inverted before sync
// - p_db_cycles   1200000   consecutive stable synced samples to accept a change (>=2)
// - p_long_cycles 12000000  cycles held after o_press before o_long fires (>p_db_cycles)
// PORTS
// - i_clk      in   1  clock; all logic on posedge
// - i_rst      in   1  reset, synchronous, active-high
// - i_btn      in   1  raw button pin, asynchronous, may bounce
// - o_level    out  1  debounced state, 1 = pressed
// - o_press    out  1  1-cycle pulse, first cycle o_level=1
// - o_release  out  1  1-cycle pulse, first cycle o_level=0
// - o_long     out  1  1-cycle pulse, once per press, after p_long_cycles held
// - o_count    out  8  number of accepted presses, mod 256
// BEHAVIOUR
// - Input path: optional inversion (p_active_low), then 2-flop synchronizer
//   (s1, s2). Both flops reset to 0 (released). FSM sees only s2.
// - States and transitions:
//   - S_UP: s2=1 -> S_DN_WAIT, db_cnt=1.
//   - S_DN_WAIT: s2=1 -> db_cnt+1.
//     s2=0 -> S_UP, db_cnt=0.
//     s2=1 with db_cnt==p_db_cycles-1 -> S_DOWN; register o_level=1,
//     o_press=1, o_count+1.
//   - S_DOWN: s2=0 -> S_UP_WAIT, db_cnt=1.
//     Otherwise hold_cnt+1, saturating at p_long_cycles.
//     hold_cnt reaching p_long_cycles-1 -> o_long=1 for that single cycle.
//   - S_UP_WAIT: mirror of S_DN_WAIT. s2=1 -> S_DOWN, db_cnt=0, hold_cnt kept.
//     db_cnt==p_db_cycles-1 with s2=0 -> S_UP; register o_level=0,
//     o_release=1, hold_cnt=0.
// - Latency: raw first sampled active at edge k and held thereafter ->
//   o_level/o_press rise at edge k+1+p_db_cycles (2 sync stages plus
//   p_db_cycles samples, first sample at k+2). Release latency is identical.
// - Glitch/bounce: any reversal before db_cnt completes restarts the count;
//   o_level never toggles and no pulse is emitted.
// - Long press:
//   - o_long fires exactly p_long_cycles cycles after the o_press cycle, at
//     most once per press, with no auto-repeat.
//   - Bounces in S_UP_WAIT that return to S_DOWN do not clear hold_cnt.
//   - A release accepted before o_long suppresses it.
// - o_press, o_release and o_long are never asserted in the same cycle; o_long
//   requires S_DOWN.
// - o_count wraps 255 -> 0 on the 256th press; no flag.
// - Counter widths: db_cnt $clog2(p_db_cycles+1), hold_cnt
//   $clog2(p_long_cycles+1); no overflow due to saturation.
// - Reset:
//   - State S_UP; s1, s2, db_cnt, hold_cnt, o_count=0; o_level=0, all pulses 0.
//   - Reset overrides every state mid-debounce or mid-hold; no pulse is emitted
//     on the reset cycle or the cycle after.
//   - Button held through reset: treated as a fresh press after release of
//     i_rst, same latency counted from the first post-reset sampling edge.
// - All outputs are registered; no combinational path from i_btn.
// TESTING (p_db_cycles=4, p_long_cycles=16, p_active_low=0 unless stated)
// - Clean press at edge 10, held 40 cycles -> o_press at edge 15, o_count=1,
//   o_long at edge 31, none at 47.
// - Bounce 1,0,1,0,1 (1 cycle each) then steady 1 -> no event during bounce;
//   single o_press 5 cycles after the steady 1 begins.
// - Press 10 cycles then release -> o_press, then o_release 5 cycles after the
//   release edge; no o_long; o_level back to 0.
// - 257 clean presses -> o_count reads 1; exactly 257 o_press and 257
//   o_release pulses.
// - i_rst at cycle 2 of S_DN_WAIT with button held, released from reset
//   3 cycles later -> all outputs 0 during reset; o_press 5 edges after reset
//   deasserts.
// - p_active_low=1, pin driven 0 -> o_level=1 and o_press after 5 edges;
//   pin 1 at reset -> o_level stays 0.

Source files
------------

// File: rtl/button_debounce.sv
// button_debounce: turns one raw, bouncing push-button pin into clean,
// clock-synchronous events: debounced level, press/release pulses, a single
// long-press pulse and a wrapping 8-bit press counter. All outputs registered.
module button_debounce #(
    parameter int p_active_low  = 0,
    parameter int p_db_cycles   = 1200000,
    parameter int p_long_cycles = 12000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn,
    output logic       o_level,
    output logic       o_press,
    output logic       o_release,
    output logic       o_long,
    output logic [7:0] o_count
);

    localparam int DB_W   = $clog2(p_db_cycles + 1);
    localparam int HOLD_W = $clog2(p_long_cycles + 1);

    localparam logic [DB_W-1:0]   DB_ZERO   = '0;
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(p_db_cycles - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = '0;
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(p_long_cycles - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(p_long_cycles);
    localparam logic              ACT_LOW   = (p_active_low != 0);

    typedef enum logic [1:0] {
        S_UP,
        S_DN_WAIT,
        S_DOWN,
        S_UP_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              btn_pressed;
    logic              s1_q, s2_q;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic [7:0]        count_q, count_d;

    // Normalise the pin so that 1 always means pressed.
    assign btn_pressed = i_btn ^ ACT_LOW;

    // Two-flop synchronizer; both stages come out of reset as released.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_pressed;
            s2_q <= s1_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_UP;
            db_cnt_q   <= DB_ZERO;
            hold_cnt_q <= HOLD_ZERO;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            count_q    <= count_d;
        end
    end

    // Next-state logic: a change is accepted only after p_db_cycles
    // consecutive agreeing samples; any reversal restarts the count.
    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        count_d    = count_q;

        case (state_q)
            S_UP: begin
                if (s2_q) begin
                    state_d  = S_DN_WAIT;
                    db_cnt_d = DB_ONE;
                end
            end

            S_DN_WAIT: begin
                if (!s2_q) begin
                    state_d  = S_UP;
                    db_cnt_d = DB_ZERO;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = S_DOWN;
                    db_cnt_d   = DB_ZERO;
                    hold_cnt_d = HOLD_ZERO;
                    level_d    = 1'b1;
                    press_d    = 1'b1;
                    count_d    = count_q + 8'd1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end

            S_DOWN: begin
                if (!s2_q) begin
                    state_d  = S_UP_WAIT;
                    db_cnt_d = DB_ONE;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                    if (hold_cnt_q == HOLD_LAST) begin
                        long_d = 1'b1;
                    end
                end
            end

            S_UP_WAIT: begin
                if (s2_q) begin
                    state_d  = S_DOWN;
                    db_cnt_d = DB_ZERO;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = S_UP;
                    db_cnt_d   = DB_ZERO;
                    hold_cnt_d = HOLD_ZERO;
                    level_d    = 1'b0;
                    release_d  = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end

            default: begin
                state_d  = S_UP;
                db_cnt_d = DB_ZERO;
            end
        endcase
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_long    = long_q;
    assign o_count   = count_q;

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: drives an active-high and an active-low debouncer with
// directed scenarios and random bouncing input, comparing every cycle against
// a sliding-window reference model.
module tb_button_debounce;
    localparam int DB   = 4;
    localparam int LONG = 16;

    logic       clock = 1'b0;
    logic       rst;
    logic       btnH, btnL;
    logic       levelH, pressH, releaseH, longH;
    logic       levelL, pressL, releaseL, longL;
    logic [7:0] countH, countL;

    int checks = 0;
    int errors = 0;

    int stepIdx, pressSeen, releaseSeen, longSeen, pressSeenL;
    int firstPress, firstRelease, firstLong, firstPressL;
    int unsigned segLen;

    always #5 clock = ~clock;

    button_debounce #(.p_active_low(0), .p_db_cycles(DB), .p_long_cycles(LONG)) dutH (
        .i_clk(clock), .i_rst(rst), .i_btn(btnH),
        .o_level(levelH), .o_press(pressH), .o_release(releaseH),
        .o_long(longH), .o_count(countH)
    );

    button_debounce #(.p_active_low(1), .p_db_cycles(DB), .p_long_cycles(LONG)) dutL (
        .i_clk(clock), .i_rst(rst), .i_btn(btnL),
        .o_level(levelL), .o_press(pressL), .o_release(releaseL),
        .o_long(longL), .o_count(countL)
    );

    // Reference model: raw pin delayed two edges, level flips when the last
    // DB delayed samples all disagree with it, hold time counts uninterrupted
    // pressed samples after the press.
    bit [1:0]    pipe    [2];
    bit [DB-1:0] hist    [2];
    bit          prevS   [2];
    int          hold    [2];
    bit          mLevel  [2];
    bit          mPress  [2];
    bit          mRelease[2];
    bit          mLong   [2];
    bit [7:0]    mCount  [2];

    always @(posedge clock) begin : model
        bit raw, s, flip;
        for (int u = 0; u < 2; u++) begin
            raw = (u == 0) ? btnH : !btnL;
            mPress[u]   = 1'b0;
            mRelease[u] = 1'b0;
            mLong[u]    = 1'b0;
            if (rst) begin
                pipe[u]   = 2'b00;
                hist[u]   = '0;
                prevS[u]  = 1'b0;
                hold[u]   = 0;
                mLevel[u] = 1'b0;
                mCount[u] = 8'd0;
            end else begin
                s       = pipe[u][1];
                pipe[u] = {pipe[u][0], raw};
                hist[u] = {hist[u][DB-2:0], s};
                if (mLevel[u] && s && prevS[u] && hold[u] < LONG) begin
                    hold[u] = hold[u] + 1;
                    if (hold[u] == LONG) mLong[u] = 1'b1;
                end
                flip = mLevel[u] ? (hist[u] == '0) : (hist[u] == '1);
                if (flip) begin
                    mLevel[u] = !mLevel[u];
                    hold[u]   = 0;
                    if (mLevel[u]) begin
                        mPress[u] = 1'b1;
                        mCount[u] = mCount[u] + 8'd1;
                    end else begin
                        mRelease[u] = 1'b1;
                    end
                end
                prevS[u] = s;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        checkOutput("levelH",   32'(levelH),   32'(mLevel[0]));
        checkOutput("pressH",   32'(pressH),   32'(mPress[0]));
        checkOutput("releaseH", 32'(releaseH), 32'(mRelease[0]));
        checkOutput("longH",    32'(longH),    32'(mLong[0]));
        checkOutput("countH",   32'(countH),   32'(mCount[0]));
        checkOutput("levelL",   32'(levelL),   32'(mLevel[1]));
        checkOutput("pressL",   32'(pressL),   32'(mPress[1]));
        checkOutput("releaseL", 32'(releaseL), 32'(mRelease[1]));
        checkOutput("longL",    32'(longL),    32'(mLong[1]));
        checkOutput("countL",   32'(countL),   32'(mCount[1]));
    end

    task automatic clearTally();
        stepIdx      = 0;
        pressSeen    = 0;
        releaseSeen  = 0;
        longSeen     = 0;
        pressSeenL   = 0;
        firstPress   = -1;
        firstRelease = -1;
        firstLong    = -1;
        firstPressL  = -1;
    endtask

    // Drive both pins, then step the given number of cycles while tallying
    // pulses; step index 0 is the first edge that samples the new values.
    task automatic applyStimulus(input logic h, input logic l, input int cycles);
        btnH = h;
        btnL = l;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (pressH) begin
                if (firstPress < 0) firstPress = stepIdx;
                pressSeen++;
            end
            if (releaseH) begin
                if (firstRelease < 0) firstRelease = stepIdx;
                releaseSeen++;
            end
            if (longH) begin
                if (firstLong < 0) firstLong = stepIdx;
                longSeen++;
            end
            if (pressL) begin
                if (firstPressL < 0) firstPressL = stepIdx;
                pressSeenL++;
            end
            stepIdx++;
        end
    endtask

    initial begin
        rst  = 1'b1;
        btnH = 1'b0;
        btnL = 1'b1;
        clearTally();
        repeat (3) @(negedge clock);
        rst = 1'b0;
        checkOutput("reset levelH", 32'(levelH), 32'd0);
        checkOutput("reset countH", 32'(countH), 32'd0);
        checkOutput("reset levelL", 32'(levelL), 32'd0);

        // Active-low pin idle high: nothing happens; driven low: press.
        clearTally();
        applyStimulus(1'b0, 1'b1, 20);
        checkOutput("idle pressL", 32'(pressSeenL), 32'd0);
        checkOutput("idle levelL", 32'(levelL), 32'd0);
        clearTally();
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("activeLow latency", 32'(firstPressL), 32'd5);
        checkOutput("activeLow level", 32'(levelL), 32'd1);
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput("activeLow released", 32'(levelL), 32'd0);

        // Clean long hold: press at +5, single long pulse 16 later.
        clearTally();
        applyStimulus(1'b1, 1'b1, 60);
        checkOutput("clean press latency", 32'(firstPress), 32'd5);
        checkOutput("long offset", 32'(firstLong - firstPress), 32'd16);
        checkOutput("long once", 32'(longSeen), 32'd1);
        checkOutput("count after press", 32'(countH), 32'd1);
        clearTally();
        applyStimulus(1'b0, 1'b1, 20);
        checkOutput("release latency", 32'(firstRelease), 32'd5);
        checkOutput("level after release", 32'(levelH), 32'd0);

        // Bounce 1,0,1,0 then steady 1 from the fifth edge.
        clearTally();
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 20);
        checkOutput("bounce presses", 32'(pressSeen), 32'd1);
        checkOutput("bounce press time", 32'(firstPress), 32'd9);
        applyStimulus(1'b0, 1'b1, 12);

        // Short press: release accepted before long suppresses it.
        clearTally();
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 20);
        checkOutput("short press time", 32'(firstPress), 32'd5);
        checkOutput("short release time", 32'(firstRelease), 32'd15);
        checkOutput("short no long", 32'(longSeen), 32'd0);
        checkOutput("short level", 32'(levelH), 32'd0);

        // 257 presses wrap the counter to 1.
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 2);
        rst = 1'b0;
        clearTally();
        repeat (257) begin
            applyStimulus(1'b1, 1'b1, 8);
            applyStimulus(1'b0, 1'b1, 8);
        end
        checkOutput("wrap presses", 32'(pressSeen), 32'd257);
        checkOutput("wrap releases", 32'(releaseSeen), 32'd257);
        checkOutput("wrap count", 32'(countH), 32'd1);

        // Reset in the middle of a debounce with the button held.
        clearTally();
        applyStimulus(1'b1, 1'b1, 3);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("rst level", 32'(levelH), 32'd0);
            checkOutput("rst pulses", 32'({pressH, releaseH, longH}), 32'd0);
            checkOutput("rst count", 32'(countH), 32'd0);
        end
        rst = 1'b0;
        clearTally();
        applyStimulus(1'b1, 1'b1, 12);
        checkOutput("post-reset press time", 32'(firstPress), 32'd5);
        checkOutput("post-reset count", 32'(countH), 32'd1);
        applyStimulus(1'b0, 1'b1, 12);

        // Random bouncing on both pins with occasional resets.
        repeat (200) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                applyStimulus(btnH, btnL, int'($urandom_range(1, 3)));
                rst = 1'b0;
            end
            segLen = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 30) : $urandom_range(1, 4);
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'(segLen));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
